// File: rtl/peripheral_uart_rxfifo.sv
// rtl/peripheral_uart_rxfifo.sv - 8N1 UART receiver with 16-entry receive FIFO on the J1 I/O bus
module peripheral_uart_rxfifo #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_avail
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            sync1, rxs, rxs_q;

    logic [7:0]      mem [16];
    logic [3:0]      wptr, rptr;
    logic [4:0]      count;
    logic            ovr, ferr;

    logic            full, empty;
    logic            stop_hit, push, ferr_set;
    logic            pop, flush, ovr_clr, ferr_clr;
    logic            do_push, ovr_set;
    logic            unused_d_in;

    assign full     = (count == 5'd16);
    assign empty    = (count == 5'd0);
    assign rx_avail = !empty;

    // The stop sample drives the FIFO directly so the byte lands on the same edge.
    assign stop_hit = (state == S_STOP) && (cnt == '0);
    assign push     = stop_hit && rxs;
    assign ferr_set = stop_hit && !rxs;

    assign pop      = cs && rd && (addr == 4'h0) && !empty;
    assign flush    = cs && wr && (addr == 4'h4) && d_in[0];
    assign ovr_clr  = cs && wr && (addr == 4'h4) && d_in[1];
    assign ferr_clr = cs && wr && (addr == 4'h4) && d_in[2];

    // A full FIFO still accepts a byte when a pop frees the head in the same cycle.
    assign do_push  = push && (!full || pop) && !flush;
    assign ovr_set  = push && full && !pop && !flush;

    assign unused_d_in = ^d_in[15:3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            sync1 <= uart_rx;
            rxs   <= sync1;
            rxs_q <= rxs;
            case (state)
                S_IDLE: begin
                    if (rxs_q && !rxs) begin
                        cnt   <= HALF_M1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (!rxs) begin
                            cnt     <= DIV_M1;
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shift[bit_idx] <= rxs;
                        cnt            <= DIV_M1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= 4'd0;
            rptr  <= 4'd0;
            count <= 5'd0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= 4'd0;
                rptr  <= 4'd0;
                count <= 5'd0;
            end else begin
                if (do_push) wptr <= wptr + 4'd1;
                if (pop)     rptr <= rptr + 4'd1;
                count <= count + {4'd0, do_push} - {4'd0, pop};
            end
            if (ovr_set)       ovr <= 1'b1;
            else if (ovr_clr)  ovr <= 1'b0;
            if (ferr_set)      ferr <= 1'b1;
            else if (ferr_clr) ferr <= 1'b0;
        end
    end

    always_comb begin
        d_out = 16'h0000;
        case (addr)
            4'h0:    d_out = empty ? 16'h0000 : {8'h00, mem[rptr]};
            4'h2:    d_out = {7'b0, ferr, ovr, count, full, empty};
            default: d_out = 16'h0000;
        endcase
    end
endmodule

// File: tb/tb_peripheral_uart_rxfifo.sv
// tb/tb_peripheral_uart_rxfifo.sv - randomized self-checking bench for peripheral_uart_rxfifo
module tb_peripheral_uart_rxfifo;
    localparam int TB_CLK  = 1600;
    localparam int TB_BAUD = 100;
    localparam int TB_DIV  = TB_CLK / TB_BAUD;
    localparam int TB_HALF = TB_DIV / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = 16'h0;
    logic        cs = 1'b0;
    logic [3:0]  addr = 4'h2;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic        uart_rx = 1'b1;
    logic        rx_avail;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    peripheral_uart_rxfifo #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(d_out), .uart_rx(uart_rx), .rx_avail(rx_avail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        int n = q.size();
        return {7'b0, m_ferr, m_ovr, n[4:0], n == 16, n == 0};
    endfunction

    task automatic reg_read(input logic [3:0] a, output logic [15:0] data);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 data = d_out;
        @(posedge clk);
        #1 cs = 1'b0; rd = 1'b0; addr = 4'h2;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(posedge clk);
        #1 cs = 1'b0; wr = 1'b0; addr = 4'h2; d_in = 16'h0;
        if (a == 4'h4) begin
            if (v[0]) q.delete();
            if (v[1]) m_ovr = 1'b0;
            if (v[2]) m_ferr = 1'b0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [15:0] s;
        reg_read(4'h2, s);
        chk(tag, s, exp_status());
        chk({tag, "_avail"}, {15'b0, rx_avail}, {15'b0, q.size() != 0});
    endtask

    task automatic check_pop(input string tag);
        logic [15:0] r;
        logic [15:0] e;
        e = (q.size() != 0) ? {8'h00, q.pop_front()} : 16'h0000;
        reg_read(4'h0, r);
        chk(tag, r, e);
    endtask

    // Frame drive starts at a falling clock edge; rst_bit >= 0 pulses reset mid data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit do_model, input int rst_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (TB_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            if (i == rst_bit) begin
                repeat (TB_DIV / 2) @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                repeat (TB_DIV - TB_DIV / 2 - 2) @(negedge clk);
            end else begin
                repeat (TB_DIV) @(negedge clk);
            end
        end
        uart_rx = stop_bit;
        repeat (TB_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 + $urandom_range(0, TB_DIV)) @(negedge clk);
        if (do_model) begin
            if (!stop_bit) m_ferr = 1'b1;
            else if (q.size() < 16) q.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [7:0]  nb;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        check_status("reset_status");

        send_frame(8'hA5, 1'b1, 1'b1, -1);
        check_status("a5_status");
        check_pop("a5_read");
        check_status("a5_after");

        for (int i = 0; i <= 16; i++) send_frame(i[7:0], 1'b1, 1'b1, -1);
        reg_read(4'h2, r);
        chk("full_ovr_status", r, 16'h00C2);
        for (int i = 0; i < 17; i++) check_pop($sformatf("drain%0d", i));
        reg_write(4'h4, 16'h0002);
        check_status("ovr_cleared");

        send_frame(8'h3C, 1'b0, 1'b1, -1);
        check_status("ferr_status");
        send_frame(8'h55, 1'b1, 1'b1, -1);
        check_pop("after_ferr_read");
        reg_write(4'h4, 16'h0004);
        check_status("ferr_cleared");

        @(negedge clk);
        uart_rx = 1'b0;
        repeat (TB_DIV / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * TB_DIV) @(negedge clk);
        check_status("glitch");
        send_frame(8'hC3, 1'b1, 1'b1, -1);
        check_pop("after_glitch");

        reg_write(4'h7, 16'hFFFF);
        reg_read(4'h9, r);
        chk("unmapped", r, 16'h0000);

        for (int it = 0; it < 30; it++) begin
            int nf = $urandom_range(1, 6);
            int nr = $urandom_range(0, 7);
            for (int f = 0; f < nf; f++)
                send_frame(8'($urandom), ($urandom_range(0, 9) != 0), 1'b1, -1);
            check_status($sformatf("rnd_st%0d", it));
            for (int k = 0; k < nr; k++) check_pop($sformatf("rnd_rd%0d_%0d", it, k));
            if ($urandom_range(0, 3) == 0) reg_write(4'h4, 16'($urandom_range(0, 7)));
        end

        reg_write(4'h4, 16'h0007);
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b1, -1);
        check_status("pre_pushpop");
        nb = 8'($urandom);
        fork
            send_frame(nb, 1'b1, 1'b0, -1);
            begin
                @(negedge clk);
                repeat (2 + TB_HALF + 9 * TB_DIV) @(negedge clk);
                cs = 1'b1; rd = 1'b1; addr = 4'h0;
                #1 chk("pushpop_head", d_out, {8'h00, q.pop_front()});
                @(posedge clk);
                #1 cs = 1'b0; rd = 1'b0; addr = 4'h2;
                q.push_back(nb);
            end
        join
        check_status("pushpop_status");
        for (int i = 0; i < 16; i++) check_pop($sformatf("pushpop_rd%0d", i));

        send_frame(8'h11, 1'b1, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b0, 4);
        q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        reg_read(4'h2, r);
        chk("midreset_status", r, 16'h0001);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        check_status("midreset_next");
        check_pop("midreset_81");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
